// File: rtl/f_muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and the mul/div sequencer (slave).
// Defining MULDIV_UNSIGNED_EN adds the unsgn request bit.
interface f_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
`ifdef MULDIV_UNSIGNED_EN
  logic             unsgn;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULDIV_UNSIGNED_EN
  modport master (output start, op, unsgn, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, unsgn, a, b, output busy, done, div_zero, hi, lo);
`else
  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/f_muldiv_seq.sv
// Multicycle signed multiply / restoring divide sequencer owning HI/LO.
// Optional MULDIV_UNSIGNED_EN adds MULTU/DIVU via the interface's unsgn bit.
module f_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  f_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FIN, ST_DZ} state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic                 op_r, unsgn_r, neg_q_r, neg_r_r;
  logic                 busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0]     a_r, b_r, opnd_r, hi_r, lo_r;
  logic [2*WIDTH-1:0]   p_r, p_next_s, prod_s;
  logic [WIDTH:0]       sum_s, shl_s;
  logic [WIDTH-1:0]     dif_s, quo_s, rem_s;
  logic                 ge_s, unsgn_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic uns);
    logic [WIDTH-1:0] m;
    if (!uns && x[WIDTH-1]) m = neg_w(x);
    else                    m = x;
    return m;
  endfunction

`ifdef MULDIV_UNSIGNED_EN
  assign unsgn_s = bus.unsgn;
`else
  assign unsgn_s = 1'b0;
`endif

  // One iteration: upper half accumulates (MULT) or holds the partial remainder (DIV).
  always_comb begin
    sum_s = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    shl_s = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
    ge_s  = (shl_s >= {1'b0, opnd_r});
    if (ge_s) dif_s = shl_s[WIDTH-1:0] - opnd_r;
    else      dif_s = shl_s[WIDTH-1:0];
    if (op_r) p_next_s = {dif_s, p_r[WIDTH-2:0], ge_s};
    else      p_next_s = {sum_s, p_r[WIDTH-1:1]};
  end

  // Sign fix of the magnitude result; remainder follows the dividend sign.
  always_comb begin
    if (neg_q_r) prod_s = neg_2w(p_r);
    else         prod_s = p_r;
    if (neg_q_r) quo_s = neg_w(p_r[WIDTH-1:0]);
    else         quo_s = p_r[WIDTH-1:0];
    if (neg_r_r) rem_s = neg_w(p_r[2*WIDTH-1:WIDTH]);
    else         rem_s = p_r[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered status and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      op_r       <= 1'b0;
      unsgn_r    <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      p_r        <= {(2*WIDTH){1'b0}};
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            op_r    <= bus.op;
            unsgn_r <= unsgn_s;
            if (bus.op && (bus.b == {WIDTH{1'b0}})) begin
              state_r <= ST_DZ;
            end else begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // Divisor or multiplicand stays put; the other operand shifts through p_r.
          opnd_r  <= op_r ? mag(b_r, unsgn_r) : mag(a_r, unsgn_r);
          p_r     <= {{WIDTH{1'b0}}, (op_r ? mag(a_r, unsgn_r) : mag(b_r, unsgn_r))};
          neg_q_r <= !unsgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r_r <= !unsgn_r && a_r[WIDTH-1];
          cnt_r   <= {CW{1'b0}};
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          p_r   <= p_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) state_r <= ST_FIN;
        end
        ST_FIN: begin
          if (op_r) begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_DZ: begin
          div_zero_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: tb/tb_f_muldiv_seq.sv
// Self-checking bench for f_muldiv_seq: directed vector table, random ops vs. arithmetic model,
// and hand sequences for divide-by-zero, start-while-busy, back-to-back start and async reset.
module tb_f_muldiv_seq;
  typedef struct {
    bit          op;
    bit          uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  f_muldiv_seq_if #(.WIDTH(32)) bus_i ();

  f_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic logic [63:0] model(input bit op_i, input logic [31:0] a_i,
                                        input logic [31:0] b_i, input bit uns_i);
    longint la, lb, q, r, p;
    if (uns_i) begin
      la = longint'({32'd0, a_i});
      lb = longint'({32'd0, b_i});
    end else begin
      la = longint'($signed(a_i));
      lb = longint'($signed(b_i));
    end
    if (!op_i) begin
      p = la * lb;
      return p;
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic drive_uns(input bit u);
`ifdef MULDIV_UNSIGNED_EN
    bus_i.unsgn = u;
`else
    if (u) $display("note: unsigned request ignored in signed build");
`endif
  endtask

  task automatic wait_done(output int n, output bit dz, output bit stable);
    logic [31:0] hi0, lo0;
    hi0 = bus_i.hi;
    lo0 = bus_i.lo;
    n = 0;
    dz = 1'b0;
    stable = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus_i.done || bus_i.div_zero) begin
        dz = bus_i.div_zero;
        break;
      end
      if (!bus_i.busy || bus_i.hi !== hi0 || bus_i.lo !== lo0) stable = 1'b0;
    end
  endtask

  task automatic do_op(input bit op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input bit uns_i, output int n, output bit dz, output bit stable,
                       output bit bacc);
    @(negedge clk);
    bus_i.op = op_i;
    bus_i.a = a_i;
    bus_i.b = b_i;
    drive_uns(uns_i);
    bus_i.start = 1'b1;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    bacc = bus_i.busy;
    wait_done(n, dz, stable);
  endtask

  vec_t        vecs[$];
  int          n, n2;
  bit          dz, stable, bacc, seen;
  bit          rop, runs;
  logic [31:0] ra, rb, hi0, lo0;
  logic [63:0] exp64;

  initial begin
    vecs.push_back('{1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
`ifdef MULDIV_UNSIGNED_EN
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF});
`endif

    bus_i.start = 1'b0;
    bus_i.op = 1'b0;
    bus_i.a = 32'd0;
    bus_i.b = 32'd0;
    drive_uns(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, bus_i.busy}, 64'd0);
    chk("reset_done", {63'd0, bus_i.done}, 64'd0);
    chk("reset_div_zero", {63'd0, bus_i.div_zero}, 64'd0);
    chk("reset_hi", {32'd0, bus_i.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus_i.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].uns, n, dz, stable, bacc);
      chk($sformatf("vec%0d_hi", i), {32'd0, bus_i.hi}, {32'd0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, bus_i.lo}, {32'd0, vecs[i].lo});
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'd34);
      chk($sformatf("vec%0d_busy_hold", i), {63'd0, stable}, 64'd1);
      chk($sformatf("vec%0d_busy_accept", i), {63'd0, bacc}, 64'd1);
    end

    for (int k = 0; k < 40; k++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (rop && rb == 32'd0) rb = 32'd1;
`ifdef MULDIV_UNSIGNED_EN
      runs = 1'($urandom_range(0, 1));
`else
      runs = 1'b0;
`endif
      exp64 = model(rop, ra, rb, runs);
      do_op(rop, ra, rb, runs, n, dz, stable, bacc);
      chk($sformatf("rnd%0d_op%0d_a%h_b%h_u%0d", k, rop, ra, rb, runs),
          {bus_i.hi, bus_i.lo}, exp64);
      chk($sformatf("rnd%0d_latency", k), 64'(n), 64'd34);
    end

    // Divide by zero: single div_zero pulse, HI/LO untouched, never busy, no done.
    hi0 = bus_i.hi;
    lo0 = bus_i.lo;
    do_op(1'b1, 32'd5, 32'd0, 1'b0, n, dz, stable, bacc);
    chk("dz_pulse", {63'd0, dz}, 64'd1);
    chk("dz_latency", 64'(n), 64'd1);
    chk("dz_busy", {63'd0, bacc}, 64'd0);
    chk("dz_hilo", {bus_i.hi, bus_i.lo}, {hi0, lo0});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_i.done || bus_i.busy || bus_i.div_zero) seen = 1'b1;
    end
    chk("dz_quiet_after", {63'd0, seen}, 64'd0);

    // Start during a MULT is ignored, and operand changes mid-run have no effect.
    exp64 = model(1'b0, 32'd1234, 32'hFFFFE9D2, 1'b0);
    @(negedge clk);
    bus_i.op = 1'b0;
    bus_i.a = 32'd1234;
    bus_i.b = 32'hFFFFE9D2;
    bus_i.start = 1'b1;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus_i.op = 1'b1;
    bus_i.a = 32'd9;
    bus_i.b = 32'd3;
    bus_i.start = 1'b1;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    bus_i.a = $urandom;
    bus_i.b = 32'd0;
    wait_done(n2, dz, stable);
    chk("ignore_result", {bus_i.hi, bus_i.lo}, exp64);
    chk("ignore_latency", 64'(10 + n2), 64'd34);
    chk("ignore_no_dz", {63'd0, dz}, 64'd0);

    // New start in the done cycle is accepted immediately.
    exp64 = model(1'b1, 32'd100, 32'd7, 1'b0);
    bus_i.op = 1'b1;
    bus_i.a = 32'd100;
    bus_i.b = 32'd7;
    bus_i.start = 1'b1;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    chk("b2b_accept", {63'd0, bus_i.busy}, 64'd1);
    wait_done(n, dz, stable);
    chk("b2b_result", {bus_i.hi, bus_i.lo}, exp64);
    chk("b2b_latency", 64'(n), 64'd34);

    // Async reset in the middle of the next operation.
    bus_i.op = 1'b0;
    bus_i.a = 32'h12345678;
    bus_i.b = 32'h00000003;
    bus_i.start = 1'b1;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, bus_i.busy}, 64'd0);
    chk("midrst_hilo", {bus_i.hi, bus_i.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_i.done || bus_i.busy || bus_i.div_zero || bus_i.hi != 32'd0) seen = 1'b1;
    end
    chk("midrst_quiet_after", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
